// File: rtl/uart_pkg.sv
// Shared encodings for the UART transmit path: engine states, parity modes,
// character lengths, threshold selects and the parity helpers.
package uart_pkg;

    typedef logic [2:0] tx_state_e;

    localparam tx_state_e ST_IDLE   = 3'd0;
    localparam tx_state_e ST_START  = 3'd1;
    localparam tx_state_e ST_DATA   = 3'd2;
    localparam tx_state_e ST_PARITY = 3'd3;
    localparam tx_state_e ST_STOP   = 3'd4;
    localparam tx_state_e ST_BREAK  = 3'd5;

    localparam logic [2:0] PAR_NONE  = 3'b000;
    localparam logic [2:0] PAR_ODD   = 3'b001;
    localparam logic [2:0] PAR_EVEN  = 3'b010;
    localparam logic [2:0] PAR_MARK  = 3'b011;
    localparam logic [2:0] PAR_SPACE = 3'b100;

    localparam logic [1:0] LEN_5 = 2'b00;
    localparam logic [1:0] LEN_6 = 2'b01;
    localparam logic [1:0] LEN_7 = 2'b10;
    localparam logic [1:0] LEN_8 = 2'b11;

    localparam logic [1:0] THR_DM1  = 2'b00;
    localparam logic [1:0] THR_3Q   = 2'b01;
    localparam logic [1:0] THR_HALF = 2'b10;
    localparam logic [1:0] THR_1Q   = 2'b11;

    function automatic logic par_enabled(input logic [2:0] mode);
        logic en;
        case (mode)
            PAR_ODD, PAR_EVEN, PAR_MARK, PAR_SPACE: en = 1'b1;
            PAR_NONE: en = 1'b0;
            default:  en = 1'b0;
        endcase
        return en;
    endfunction

    // Parity covers only the valid low bits of the character.
    function automatic logic par_bit(input logic [7:0] data, input logic [1:0] len,
                                     input logic [2:0] mode);
        logic [7:0] mask;
        logic       p;
        case (len)
            LEN_5:   mask = 8'h1F;
            LEN_6:   mask = 8'h3F;
            LEN_7:   mask = 8'h7F;
            LEN_8:   mask = 8'hFF;
            default: mask = 8'hFF;
        endcase
        case (mode)
            PAR_ODD:   p = ~^(data & mask);
            PAR_EVEN:  p = ^(data & mask);
            PAR_MARK:  p = 1'b1;
            PAR_SPACE: p = 1'b0;
            default:   p = 1'b1;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers; drops writes when full and flags
// the attempt with a one-cycle overflow pulse.
module uart_sync_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [WIDTH-1:0]           data_i,
    output logic [WIDTH-1:0]           data_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     level_o,
    output logic                       ovf_o
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wptr_q;
    logic [AW:0]      rptr_q;
    logic             ovf_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push_s;
    logic             do_pop_s;

    assign full_o    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign empty_o   = (wptr_q == rptr_q);
    assign level_o   = wptr_q - rptr_q;
    assign data_o    = mem_q[rptr_q[AW-1:0]];
    assign ovf_o     = ovf_q;
    assign do_push_s = push_i && !full_o;
    assign do_pop_s  = pop_i && !empty_o;

    // Pointer and overflow-flag update
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            ovf_q  <= 1'b0;
        end else begin
            if (do_push_s) begin
                wptr_q <= wptr_q + (AW+1)'(1);
            end
            if (do_pop_s) begin
                rptr_q <= rptr_q + (AW+1)'(1);
            end
            ovf_q <= push_i && full_o;
        end
    end

    // Storage write port
    always_ff @(posedge clk_i) begin
        if (do_push_s) begin
            mem_q[wptr_q[AW-1:0]] <= data_i;
        end
    end

endmodule

// File: rtl/uart_tx_core.sv
// UART transmitter: write FIFO feeding a framing engine that serialises
// start, 5-8 data bits, optional parity and 1-2 stop bits, plus line break.
module uart_tx_core
    import uart_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int DATA_W     = 8,
    parameter int OVERSAMPLE = 16,
    parameter int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              bclk,
    input  logic              tx_en,
    input  logic              write_en,
    input  logic [DATA_W-1:0] data_in,
    input  logic [1:0]        char_len,
    input  logic [2:0]        parity_mode,
    input  logic              stop2,
    input  logic              send_break,
    input  logic [1:0]        tx_thr_val,
    output logic              txd,
    output logic              tx_bclk_en,
    output logic              tx_busy,
    output logic              tx_thr,
    output logic              tx_empty,
    output logic              tx_full,
    output logic              tx_ovf,
    output logic [CNT_W-1:0]  fifo_level
);

    localparam int OSW = $clog2(OVERSAMPLE);

    tx_state_e         state_q, state_d;
    logic [OSW-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [2:0]        bit_q, bit_d;
    logic [1:0]        len_q, len_d;
    logic [2:0]        pmode_q, pmode_d;
    logic              stop2_q, stop2_d;
    logic              stop_q, stop_d;
    logic              brk_rel_q, brk_rel_d;
    logic              pbit_q, pbit_d;
    logic              txd_q, txd_d;
    logic              load_s;
    logic              tick_end_s;
    logic              fifo_push_s;
    logic [DATA_W-1:0] fifo_data_s;
    logic [CNT_W-1:0]  thr_lim_s;

    // A full FIFO still sees the request so a dropped write raises overflow.
    assign fifo_push_s = write_en && (tx_en || tx_full);

    uart_sync_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(DATA_W)) u_fifo (
        .clk_i   (clk),
        .reset_i (reset),
        .push_i  (fifo_push_s),
        .pop_i   (load_s),
        .data_i  (data_in),
        .data_o  (fifo_data_s),
        .full_o  (tx_full),
        .empty_o (tx_empty),
        .level_o (fifo_level),
        .ovf_o   (tx_ovf)
    );

    assign tick_end_s = bclk && (cnt_q == OSW'(OVERSAMPLE - 1));
    assign tx_busy    = (state_q != ST_IDLE);
    assign tx_bclk_en = tx_busy;
    assign txd        = txd_q;
    assign tx_thr     = (fifo_level <= thr_lim_s);

    // Threshold limit selection
    always_comb begin
        case (tx_thr_val)
            THR_DM1:  thr_lim_s = CNT_W'(FIFO_DEPTH - 1);
            THR_3Q:   thr_lim_s = CNT_W'(3 * FIFO_DEPTH / 4);
            THR_HALF: thr_lim_s = CNT_W'(FIFO_DEPTH / 2);
            THR_1Q:   thr_lim_s = CNT_W'(FIFO_DEPTH / 4);
            default:  thr_lim_s = CNT_W'(FIFO_DEPTH - 1);
        endcase
    end

    // Frame sequencer: next state, tick/bit counters and per-frame latches
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_d     = bit_q;
        len_d     = len_q;
        pmode_d   = pmode_q;
        stop2_d   = stop2_q;
        stop_d    = stop_q;
        brk_rel_d = brk_rel_q;
        pbit_d    = pbit_q;
        load_s    = 1'b0;
        if (state_q != ST_IDLE && bclk) begin
            cnt_d = tick_end_s ? '0 : cnt_q + OSW'(1);
        end else begin
            cnt_d = cnt_q;
        end
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (send_break) begin
                    state_d   = ST_BREAK;
                    brk_rel_d = 1'b0;
                end else if (tx_en && !tx_empty) begin
                    load_s = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                if (tick_end_s) begin
                    state_d = ST_DATA;
                    bit_d   = 3'd0;
                end else begin
                    state_d = ST_START;
                end
            end
            ST_DATA: begin
                if (tick_end_s) begin
                    shift_d = {1'b0, shift_q[DATA_W-1:1]};
                    if (bit_q == ({1'b0, len_q} + 3'd4)) begin
                        stop_d  = 1'b0;
                        state_d = par_enabled(pmode_q) ? ST_PARITY : ST_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    state_d = ST_DATA;
                end
            end
            ST_PARITY: begin
                if (tick_end_s) begin
                    stop_d  = 1'b0;
                    state_d = ST_STOP;
                end else begin
                    state_d = ST_PARITY;
                end
            end
            ST_STOP: begin
                if (tick_end_s) begin
                    if (stop2_q && !stop_q) begin
                        stop_d = 1'b1;
                    end else if (send_break) begin
                        state_d   = ST_BREAK;
                        brk_rel_d = 1'b0;
                    end else if (tx_en && !tx_empty) begin
                        load_s = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    state_d = ST_STOP;
                end
            end
            ST_BREAK: begin
                // Hold low with the counter parked, then one marking bit time.
                if (!brk_rel_q) begin
                    cnt_d     = '0;
                    brk_rel_d = !send_break;
                end else if (tick_end_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_BREAK;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (load_s) begin
            shift_d = fifo_data_s;
            len_d   = char_len;
            pmode_d = parity_mode;
            stop2_d = stop2;
            pbit_d  = par_bit(fifo_data_s, char_len, parity_mode);
            cnt_d   = '0;
            state_d = ST_START;
        end else begin
            pbit_d = pbit_q;
        end
    end

    // Line level for the current state, registered one cycle later
    always_comb begin
        case (state_q)
            ST_IDLE:   txd_d = 1'b1;
            ST_START:  txd_d = 1'b0;
            ST_DATA:   txd_d = shift_q[0];
            ST_PARITY: txd_d = pbit_q;
            ST_STOP:   txd_d = 1'b1;
            ST_BREAK:  txd_d = brk_rel_q;
            default:   txd_d = 1'b1;
        endcase
    end

    // Engine state registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            shift_q   <= '0;
            bit_q     <= 3'd0;
            len_q     <= 2'd0;
            pmode_q   <= PAR_NONE;
            stop2_q   <= 1'b0;
            stop_q    <= 1'b0;
            brk_rel_q <= 1'b0;
            pbit_q    <= 1'b0;
            txd_q     <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shift_q   <= shift_d;
            bit_q     <= bit_d;
            len_q     <= len_d;
            pmode_q   <= pmode_d;
            stop2_q   <= stop2_d;
            stop_q    <= stop_d;
            brk_rel_q <= brk_rel_d;
            pbit_q    <= pbit_d;
            txd_q     <= txd_d;
        end
    end

endmodule
